// File: rtl/ccip_c1tx_arbiter_if.sv
// rtl/ccip_c1tx_arbiter_if.sv - C1 Tx header types and the requester/channel bundle of ccip_c1tx_arbiter
package ccip_c1tx_pkg;
    typedef logic [3:0] t_ccip_c1_req;
    typedef logic [1:0] t_ccip_clLen;

    localparam t_ccip_c1_req eREQ_WRLINE_I = 4'h0;
    localparam t_ccip_c1_req eREQ_WRLINE_M = 4'h1;
    localparam t_ccip_c1_req eREQ_WRPUSH_I = 4'h2;
    localparam t_ccip_c1_req eREQ_WRFENCE  = 4'h4;
    localparam t_ccip_c1_req eREQ_INTR     = 4'h6;

    localparam t_ccip_clLen eCL_LEN_1 = 2'b00;
    localparam t_ccip_clLen eCL_LEN_2 = 2'b01;
    localparam t_ccip_clLen eCL_LEN_4 = 2'b11;

    typedef struct packed {
        logic [5:0]   rsvd2;
        logic [1:0]   vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;
endpackage

interface ccip_c1tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int GID_W   = $clog2(NUM_REQ)
);
    import ccip_c1tx_pkg::*;

    logic                                c1TxAlmFull;
    logic [NUM_REQ-1:0]                  req_valid;
    t_ccip_c1_ReqMemHdr [NUM_REQ-1:0]    req_hdr;
    logic [NUM_REQ-1:0][511:0]           req_data;
    logic [NUM_REQ-1:0]                  req_ready;
    logic                                c1tx_valid;
    t_ccip_c1_ReqMemHdr                  c1tx_hdr;
    logic [511:0]                        c1tx_data;
    logic [GID_W-1:0]                    grant_id;
    logic                                protocol_err;

    modport master (
        output c1TxAlmFull, req_valid, req_hdr, req_data,
        input  req_ready, c1tx_valid, c1tx_hdr, c1tx_data, grant_id, protocol_err
    );

    modport slave (
        input  c1TxAlmFull, req_valid, req_hdr, req_data,
        output req_ready, c1tx_valid, c1tx_hdr, c1tx_data, grant_id, protocol_err
    );
endinterface

// File: rtl/ccip_c1tx_arbiter.sv
// rtl/ccip_c1tx_arbiter.sv - round-robin C1 Tx arbiter with atomic write bursts; checker under CCIP_C1TX_ARB_CHECK_EN
module ccip_c1tx_arbiter
    import ccip_c1tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GID_W   = $clog2(NUM_REQ)
) (
    input logic               clk,
    input logic               SoftReset,
    ccip_c1tx_arbiter_if.slave bus
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t           state, state_nxt;
    logic [GID_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [GID_W-1:0] owner, owner_nxt;
    logic [1:0]       beats_left, beats_left_nxt;
    logic [GID_W-1:0] win_id, acc_id;
    logic             win_found, accept;
    logic [2:0]       win_len;
    int               cand;

    function automatic logic [GID_W-1:0] next_id(input logic [GID_W-1:0] id);
        return (id == GID_W'(NUM_REQ-1)) ? '0 : id + GID_W'(1);
    endfunction

    function automatic logic is_write(input t_ccip_c1_ReqMemHdr h);
        return h.req_type inside {eREQ_WRLINE_I, eREQ_WRLINE_M, eREQ_WRPUSH_I};
    endfunction

    // Fences, interrupts and the illegal cl_len encoding all count as one beat
    function automatic logic [2:0] pkt_len(input t_ccip_c1_ReqMemHdr h);
        if (is_write(h)) begin
            case (h.cl_len)
                eCL_LEN_2: return 3'd2;
                eCL_LEN_4: return 3'd4;
                default:   return 3'd1;
            endcase
        end
        return 3'd1;
    endfunction

    // Walk downward so the last hit is the first candidate at or after rr_ptr
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_ptr;
        cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (bus.req_valid[GID_W'(cand)]) begin
                win_found = 1'b1;
                win_id    = GID_W'(cand);
            end
        end
        win_len = pkt_len(bus.req_hdr[win_id]);
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            beats_left <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            owner      <= owner_nxt;
            beats_left <= beats_left_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        owner_nxt      = owner;
        beats_left_nxt = beats_left;
        accept         = 1'b0;
        acc_id         = owner;
        case (state)
            S_IDLE: begin
                if (win_found && !bus.c1TxAlmFull) begin
                    accept = 1'b1;
                    acc_id = win_id;
                    if (win_len == 3'd1) begin
                        rr_ptr_nxt = next_id(win_id);
                    end else begin
                        state_nxt      = S_BURST;
                        owner_nxt      = win_id;
                        beats_left_nxt = 2'(win_len - 3'd1);
                    end
                end
            end
            S_BURST: begin
                // Almost-full is deliberately ignored so an open burst always drains
                if (bus.req_valid[owner]) begin
                    accept         = 1'b1;
                    beats_left_nxt = beats_left - 2'd1;
                    if (beats_left == 2'd1) begin
                        state_nxt  = S_IDLE;
                        rr_ptr_nxt = next_id(owner);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[acc_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            bus.c1tx_valid <= 1'b0;
            bus.c1tx_hdr   <= '0;
            bus.c1tx_data  <= '0;
            bus.grant_id   <= '0;
        end else begin
            bus.c1tx_valid <= accept;
            if (accept) begin
                bus.c1tx_hdr  <= bus.req_hdr[acc_id];
                bus.c1tx_data <= bus.req_data[acc_id];
                bus.grant_id  <= acc_id;
            end
        end
    end

`ifdef CCIP_C1TX_ARB_CHECK_EN
    t_ccip_c1_ReqMemHdr acc_hdr;
    logic               proto_viol;
    logic               err_q;

    always_comb begin
        acc_hdr    = bus.req_hdr[acc_id];
        proto_viol = 1'b0;
        if (accept) begin
            if (state == S_IDLE)
                proto_viol = !acc_hdr.sop || (is_write(acc_hdr) && acc_hdr.cl_len == 2'b10);
            else
                proto_viol = acc_hdr.sop;
        end
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            err_q <= 1'b0;
        end else if (proto_viol) begin
            err_q <= 1'b1;
            $display("SIM-SV: c1tx_arbiter protocol error (requester %0d)", acc_id);
        end
    end

    assign bus.protocol_err = err_q;
`else
    assign bus.protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_ccip_c1tx_arbiter.sv
// tb/tb_ccip_c1tx_arbiter.sv - scoreboard bench for ccip_c1tx_arbiter
module tb_ccip_c1tx_arbiter;
    import ccip_c1tx_pkg::*;

    localparam int N = 4;
`ifdef CCIP_C1TX_ARB_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic SoftReset = 1'b1;
    always #5 clk = ~clk;

    ccip_c1tx_arbiter_if #(.NUM_REQ(N)) bus ();
    ccip_c1tx_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .SoftReset(SoftReset), .bus(bus));

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
    } beat_t;

    typedef struct {
        int                 id;
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
    } exp_t;

    beat_t     src_mem [N][16];
    int        src_rd [N];
    int        src_wr [N];
    int        src_ex [N];
    logic [N-1:0] pause;
    exp_t      exp_q [$];
    int        total = 0;
    int        bad = 0;
    int        seq = 0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                bus.req_valid[i] = !pause[i];
                bus.req_hdr[i]   = src_mem[i][src_rd[i]].hdr;
                bus.req_data[i]  = src_mem[i][src_rd[i]].data;
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_hdr[i]   = '0;
                bus.req_data[i]  = '0;
            end
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
            src_ex[i] = 0;
        end
        pause = '0;
        exp_q.delete();
    endtask

    task automatic post(input int id, input t_ccip_c1_req t, input t_ccip_clLen l,
                        input int beats, input int bad_sop_beat);
        t_ccip_c1_ReqMemHdr h;
        for (int b = 0; b < beats; b++) begin
            seq++;
            h          = '0;
            h.req_type = t;
            h.cl_len   = l;
            h.sop      = (b == 0) || (b == bad_sop_beat);
            h.mdata    = 16'(seq);
            h.address  = 42'(seq * 64);
            src_mem[id][src_wr[id]].hdr  = h;
            src_mem[id][src_wr[id]].data = (512'(id) << 256) | 512'(seq);
            src_wr[id]++;
        end
        drive();
    endtask

    task automatic expect_next(input int id, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = id;
            e.hdr  = src_mem[id][src_ex[id]].hdr;
            e.data = src_mem[id][src_ex[id]].data;
            exp_q.push_back(e);
            src_ex[id]++;
        end
    endtask

    // One clock: inputs settled, handshake sampled mid-cycle, output checked 1 after the edge
    task automatic step(output logic [N-1:0] fired, output logic vout);
        exp_t e;
        drive();
        @(negedge clk);
        fired = bus.req_ready & bus.req_valid;
        total++;
        if ($countones(bus.req_ready) > 1) begin
            bad++;
            $display("FAIL ready_onehot: req_ready=%b required at most one bit", bus.req_ready);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (fired[i]) src_rd[i]++;
        vout = bus.c1tx_valid;
        if (vout === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: grant_id=%0d data=%0h required no output",
                         bus.grant_id, bus.c1tx_data[271:0]);
            end else begin
                e = exp_q.pop_front();
                if (bus.grant_id !== 2'(e.id) || bus.c1tx_data !== e.data || bus.c1tx_hdr !== e.hdr) begin
                    bad++;
                    $display("FAIL beat_order: grant_id=%0d mdata=%0h required grant_id=%0d mdata=%0h",
                             bus.grant_id, bus.c1tx_hdr.mdata, e.id, e.hdr.mdata);
                end
            end
        end
        drive();
    endtask

    task automatic drain(input int budget);
        logic [N-1:0] f;
        logic v;
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step(f, v);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d beats outstanding required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reset_dut();
        SoftReset = 1'b1;
        bus.c1TxAlmFull = 1'b0;
        clear_src();
        drive();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        SoftReset = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        total += 6;
        if (bus.c1tx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: %b required 0", bus.c1tx_valid); end
        if (bus.c1tx_hdr !== '0) begin bad++; $display("FAIL rst_hdr: %h required 0", bus.c1tx_hdr); end
        if (bus.c1tx_data !== '0) begin bad++; $display("FAIL rst_data: nonzero required 0"); end
        if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL rst_gid: %0d required 0", bus.grant_id); end
        if (bus.protocol_err !== 1'b0) begin bad++; $display("FAIL rst_err: %b required 0", bus.protocol_err); end
        if (bus.req_ready !== '0) begin bad++; $display("FAIL rst_ready: %b required 0", bus.req_ready); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] f;
        logic v;
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            post(0, eREQ_WRLINE_I, eCL_LEN_1, 1, -1);
            post(2, eREQ_WRLINE_I, eCL_LEN_1, 1, -1);
            expect_next(0, 1);
            expect_next(2, 1);
        end
        for (int s = 0; s < 8; s++) begin
            step(f, v);
            total++;
            if (v !== 1'b1) begin bad++; $display("FAIL rr_valid_cycle%0d: %b required 1", s, v); end
        end
        drain(4);
    endtask

    task automatic test_burst();
        logic [N-1:0] f;
        logic v;
        reset_dut();
        post(1, eREQ_WRLINE_I, eCL_LEN_4, 4, -1);
        post(3, eREQ_WRLINE_M, eCL_LEN_1, 1, -1);
        expect_next(1, 4);
        expect_next(3, 1);
        for (int s = 0; s < 5; s++) begin
            step(f, v);
            total++;
            if (v !== 1'b1) begin bad++; $display("FAIL burst_valid_cycle%0d: %b required 1", s, v); end
        end
        drain(4);
    endtask

    task automatic test_almfull();
        logic [N-1:0] f;
        logic v;
        reset_dut();
        post(0, eREQ_WRPUSH_I, eCL_LEN_4, 4, -1);
        post(1, eREQ_WRLINE_I, eCL_LEN_1, 1, -1);
        post(2, eREQ_WRFENCE, eCL_LEN_4, 1, -1);
        post(3, eREQ_WRLINE_I, eCL_LEN_1, 1, -1);
        expect_next(0, 4);
        expect_next(1, 1);
        expect_next(2, 1);
        expect_next(3, 1);
        step(f, v);
        step(f, v);
        bus.c1TxAlmFull = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step(f, v);
            total++;
            if (v !== 1'b1) begin bad++; $display("FAIL almfull_burst_beat%0d: %b required 1", s + 3, v); end
        end
        for (int s = 0; s < 3; s++) begin
            step(f, v);
            total++;
            if (f !== '0 || v !== 1'b0) begin
                bad++;
                $display("FAIL almfull_hold%0d: fired=%b valid=%b required 0/0", s, f, v);
            end
        end
        bus.c1TxAlmFull = 1'b0;
        step(f, v);
        total++;
        if (v !== 1'b1) begin bad++; $display("FAIL almfull_resume: %b required 1", v); end
        drain(6);
    endtask

    task automatic test_stall();
        logic [N-1:0] f;
        logic v;
        reset_dut();
        post(1, eREQ_WRLINE_I, eCL_LEN_4, 4, -1);
        expect_next(1, 4);
        step(f, v);
        post(0, eREQ_WRLINE_I, eCL_LEN_1, 1, -1);
        expect_next(0, 1);
        step(f, v);
        pause[1] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step(f, v);
            total++;
            if (f[0] !== 1'b0 || v !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d: ready0=%b valid=%b required 0/0", s, f[0], v);
            end
        end
        pause[1] = 1'b0;
        drain(8);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] f;
        logic v;
        reset_dut();
        post(1, eREQ_WRLINE_I, eCL_LEN_4, 4, -1);
        expect_next(1, 2);
        step(f, v);
        step(f, v);
        SoftReset = 1'b1;
        clear_src();
        step(f, v);
        total += 4;
        if (v !== 1'b0) begin bad++; $display("FAIL midrst_valid: %b required 0", v); end
        if (bus.c1tx_hdr !== '0) begin bad++; $display("FAIL midrst_hdr: %h required 0", bus.c1tx_hdr); end
        if (bus.c1tx_data !== '0) begin bad++; $display("FAIL midrst_data: nonzero required 0"); end
        if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL midrst_gid: %0d required 0", bus.grant_id); end
        SoftReset = 1'b0;
        post(3, eREQ_WRLINE_I, eCL_LEN_1, 1, -1);
        post(2, eREQ_WRLINE_I, eCL_LEN_1, 1, -1);
        expect_next(2, 1);
        expect_next(3, 1);
        drain(6);
    endtask

    task automatic test_len_types();
        reset_dut();
        post(0, eREQ_WRLINE_I, 2'b10, 1, -1);
        post(1, eREQ_WRLINE_M, eCL_LEN_2, 2, -1);
        post(2, eREQ_WRLINE_I, eCL_LEN_1, 1, -1);
        post(0, eREQ_INTR, eCL_LEN_4, 1, -1);
        expect_next(0, 1);
        expect_next(1, 2);
        expect_next(2, 1);
        expect_next(0, 1);
        drain(10);
        total++;
        if (bus.protocol_err !== EXP_ERR) begin
            bad++;
            $display("FAIL cl_len_err: %b required %b", bus.protocol_err, EXP_ERR);
        end
    endtask

    task automatic test_protocol();
        logic [N-1:0] f;
        logic v;
        reset_dut();
        total++;
        if (bus.protocol_err !== 1'b0) begin bad++; $display("FAIL proto_start: %b required 0", bus.protocol_err); end
        post(1, eREQ_WRLINE_I, eCL_LEN_4, 4, 1);
        expect_next(1, 4);
        drain(8);
        total++;
        if (bus.protocol_err !== EXP_ERR) begin
            bad++;
            $display("FAIL proto_set: %b required %b", bus.protocol_err, EXP_ERR);
        end
        step(f, v);
        step(f, v);
        total++;
        if (bus.protocol_err !== EXP_ERR) begin
            bad++;
            $display("FAIL proto_sticky: %b required %b", bus.protocol_err, EXP_ERR);
        end
        reset_dut();
        total++;
        if (bus.protocol_err !== 1'b0) begin bad++; $display("FAIL proto_clear: %b required 0", bus.protocol_err); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_almfull();
        test_stall();
        test_reset_mid();
        test_len_types();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
